// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the main-memory port arbiter; the cache controllers
// import the same state and owner types.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that did not own the last completed transfer.
module arb_select
  import mem_port_arbiter_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last,
  output owner_t grant,
  output logic   valid
);

  always_comb begin
    valid = req_i | req_d;
    grant = OWN_I;
    if (req_i && req_d) begin
      grant = (last == OWN_I) ? OWN_D : OWN_I;
    end else if (req_d) begin
      grant = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction- and data-cache block transfers onto one memory port.
// state    | meaning
// ST_IDLE  | waiting for a request while memory is not busy
// ST_ISSUE | first strobe cycle from the latched operation
// ST_WAIT  | strobe held until memory drops busywait
// ST_DONE  | owner's busywait released, LAST updated
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  arb_state_t        state, next_state;
  owner_t            owner, last, sel_grant;
  logic              sel_valid;
  logic              grant_en;
  logic              write_q;
  logic              capture_en;
  logic              strobe;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  arb_select u_select (
    .req_i (I_READ),
    .req_d (D_READ | D_WRITE),
    .last  (last),
    .grant (sel_grant),
    .valid (sel_valid)
  );

  assign grant_en   = (state == ST_IDLE) && !MEM_BUSYWAIT && sel_valid;
  assign capture_en = (state == ST_WAIT) && !MEM_BUSYWAIT && !write_q;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (grant_en) next_state = ST_ISSUE;
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT:  if (!MEM_BUSYWAIT) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      owner     <= OWN_I;
      last      <= OWN_D;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= next_state;
      if (grant_en) begin
        owner <= sel_grant;
        if (sel_grant == OWN_D) begin
          addr_q  <= D_ADDRESS;
          wdata_q <= D_WRITEDATA;
          write_q <= D_WRITE;
        end else begin
          addr_q  <= I_ADDRESS;
          write_q <= 1'b0;
        end
      end
      if (capture_en) begin
        if (owner == OWN_I) i_rdata_q <= MEM_READDATA;
        else                d_rdata_q <= MEM_READDATA;
      end
      if (state == ST_DONE) last <= owner;
    end
  end

  // Strobes decode from registered state, so a reset edge drops them at once.
  assign strobe        = (state == ST_ISSUE) || (state == ST_WAIT);
  assign MEM_READ      = strobe & ~write_q;
  assign MEM_WRITE     = strobe & write_q;
  assign MEM_ADDRESS   = addr_q;
  assign MEM_WRITEDATA = wdata_q;
  assign I_READDATA    = i_rdata_q;
  assign D_READDATA    = d_rdata_q;

  assign I_BUSYWAIT = I_READ & ~((state == ST_DONE) && (owner == OWN_I));
  assign D_BUSYWAIT = (D_READ | D_WRITE) & ~((state == ST_DONE) && (owner == OWN_D));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-programmable memory model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              I_READ = 1'b0;
  logic [ADDR_W-1:0] I_ADDRESS = '0;
  logic [DATA_W-1:0] I_READDATA;
  logic              I_BUSYWAIT;
  logic              D_READ = 1'b0;
  logic              D_WRITE = 1'b0;
  logic [ADDR_W-1:0] D_ADDRESS = '0;
  logic [DATA_W-1:0] D_WRITEDATA = '0;
  logic [DATA_W-1:0] D_READDATA;
  logic              D_BUSYWAIT;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .I_READ        (I_READ),
    .I_ADDRESS     (I_ADDRESS),
    .I_READDATA    (I_READDATA),
    .I_BUSYWAIT    (I_BUSYWAIT),
    .D_READ        (D_READ),
    .D_WRITE       (D_WRITE),
    .D_ADDRESS     (D_ADDRESS),
    .D_WRITEDATA   (D_WRITEDATA),
    .D_READDATA    (D_READDATA),
    .D_BUSYWAIT    (D_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory model: a transfer of latency lat keeps busywait high in cycles 2..lat
  // counted from the ISSUE cycle.
  int          lat = 1;
  logic [31:0] mem_rdata = '0;
  logic        mem_busy = 1'b0;
  logic        force_busy = 1'b0;
  logic        mem_started = 1'b0;
  int          mem_cnt = 0;

  assign MEM_BUSYWAIT = mem_busy | force_busy;
  assign MEM_READDATA = mem_rdata;

  always @(posedge CLK) begin
    if (RESET) begin
      mem_busy <= 1'b0; mem_cnt <= 0; mem_started <= 1'b0;
    end else if (!(MEM_READ | MEM_WRITE)) begin
      mem_busy <= 1'b0; mem_started <= 1'b0;
    end else if (!mem_started) begin
      mem_started <= 1'b1;
      if (lat > 1) begin mem_busy <= 1'b1; mem_cnt <= lat - 2; end
    end else if (mem_cnt > 0) begin
      mem_cnt <= mem_cnt - 1;
    end else begin
      mem_busy <= 1'b0;
    end
  end

  // Transfer log: one entry per rising strobe, plus a running count of read-strobe cycles.
  logic [ADDR_W-1:0] log_addr[$];
  bit                log_wr[$];
  logic [DATA_W-1:0] log_wd[$];
  int                log_cyc[$];
  int                cyc = 0;
  int                rd_seen = 0;
  logic              prev_strobe = 1'b0;

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (MEM_READ) rd_seen <= rd_seen + 1;
    if ((MEM_READ | MEM_WRITE) && !prev_strobe) begin
      log_addr.push_back(MEM_ADDRESS);
      log_wr.push_back(MEM_WRITE);
      log_wd.push_back(MEM_WRITEDATA);
      log_cyc.push_back(cyc);
    end
    prev_strobe <= MEM_READ | MEM_WRITE;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
  endtask

  task automatic wait_done(input bit is_d, input int budget, output int n);
    bit fin;
    n = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge CLK);
      n++;
      if ((is_d ? D_BUSYWAIT : I_BUSYWAIT) == 1'b0) fin = 1'b1;
      else if (n >= budget) begin
        check("wait_done_timeout", 32'(n), 32'(budget + 1));
        fin = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, base, strobes, done_at, dbw, i_done, d_done, rd0;

    // Reset values
    @(negedge CLK); RESET = 1'b0;
    check("rst_mem_read", MEM_READ, 0);
    check("rst_mem_write", MEM_WRITE, 0);
    check("rst_mem_addr", MEM_ADDRESS, 0);
    check("rst_mem_wdata", MEM_WRITEDATA, 0);
    check("rst_i_rdata", I_READDATA, 0);
    check("rst_d_rdata", D_READDATA, 0);
    check("rst_i_bw", I_BUSYWAIT, 0);
    check("rst_d_bw", D_BUSYWAIT, 0);

    // T1: single I read, 5-cycle memory
    lat = 5; mem_rdata = 32'hDEADBEEF;
    @(negedge CLK); I_READ = 1'b1; I_ADDRESS = 6'h05;
    #1 check("t1_bw_same_cycle", I_BUSYWAIT, 1);
    strobes = 0; done_at = 0; dbw = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      if (MEM_READ) strobes++;
      if (D_BUSYWAIT || MEM_WRITE) dbw++;
      if (c == 1) begin
        check("t1_issue_read", MEM_READ, 1);
        check("t1_issue_addr", MEM_ADDRESS, 6'h05);
      end
      if (I_READ && !I_BUSYWAIT) begin done_at = c; I_READ = 1'b0; end
    end
    check("t1_strobe_cycles", strobes, 6);
    check("t1_done_cycle", done_at, 7);
    check("t1_i_rdata", I_READDATA, 32'hDEADBEEF);
    check("t1_d_bw_quiet", dbw, 0);

    // T2: simultaneous I read and D write right after reset
    do_reset();
    lat = 3; base = log_addr.size();
    I_READ = 1'b1; I_ADDRESS = 6'h01;
    D_WRITE = 1'b1; D_ADDRESS = 6'h02; D_WRITEDATA = 32'h12345678;
    i_done = 0; d_done = 0; dbw = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge CLK);
      if (I_READ && !I_BUSYWAIT) begin i_done = c; I_READ = 1'b0; end
      if (D_WRITE && !D_BUSYWAIT) begin d_done = c; D_WRITE = 1'b0; end
      else if (D_WRITE) dbw++;
    end
    check("t2_i_done", i_done, 5);
    check("t2_d_done", d_done, 11);
    check("t2_d_bw_high", dbw, 10);
    check("t2_log_count", log_addr.size() - base, 2);
    if (log_addr.size() - base == 2) begin
      check("t2_first_addr", log_addr[base], 6'h01);
      check("t2_first_rd", log_wr[base], 0);
      check("t2_second_addr", log_addr[base+1], 6'h02);
      check("t2_second_wr", log_wr[base+1], 1);
      check("t2_second_wd", log_wd[base+1], 32'h12345678);
    end
    check("t2_d_rdata_kept", D_READDATA, 0);

    // T3: both held for 4 zero-latency transfers, grants alternate
    lat = 1; mem_rdata = 32'h0BADF00D; base = log_addr.size();
    @(negedge CLK);
    I_READ = 1'b1; I_ADDRESS = 6'h10;
    D_READ = 1'b1; D_ADDRESS = 6'h20;
    for (int c = 1; c <= 15; c++) begin
      @(negedge CLK);
      if (c == 15) begin
        check("t3_last_done_d", D_BUSYWAIT, 0);
        I_READ = 1'b0; D_READ = 1'b0;
      end
    end
    repeat (2) @(negedge CLK);
    check("t3_log_count", log_addr.size() - base, 4);
    if (log_addr.size() - base == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t3_grant_addr", log_addr[base+k], (k % 2 == 0) ? 6'h10 : 6'h20);
        check("t3_period", log_cyc[base+k] - log_cyc[base], 4 * k);
      end
    end
    check("t3_i_rdata", I_READDATA, 32'h0BADF00D);
    check("t3_d_rdata", D_READDATA, 32'h0BADF00D);

    // T4: D_READ and D_WRITE both high act as a write
    lat = 2; mem_rdata = 32'h11112222; base = log_addr.size(); rd0 = rd_seen;
    @(negedge CLK);
    D_READ = 1'b1; D_WRITE = 1'b1; D_ADDRESS = 6'h33; D_WRITEDATA = 32'hA5A55A5A;
    wait_done(1'b1, 20, n);
    D_READ = 1'b0; D_WRITE = 1'b0;
    check("t4_done_cycles", n, 4);
    repeat (2) @(negedge CLK);
    check("t4_no_read", rd_seen - rd0, 0);
    check("t4_log_count", log_addr.size() - base, 1);
    if (log_addr.size() - base == 1) begin
      check("t4_wr", log_wr[base], 1);
      check("t4_addr", log_addr[base], 6'h33);
      check("t4_wd", log_wd[base], 32'hA5A55A5A);
    end
    check("t4_d_rdata_kept", D_READDATA, 32'h0BADF00D);

    // T5: reset during WAIT of a D read, memory held busy afterwards
    lat = 6; mem_rdata = 32'hCAFEF00D;
    @(negedge CLK); D_READ = 1'b1; D_ADDRESS = 6'h07;
    repeat (3) @(negedge CLK);
    check("t5_in_wait", MEM_READ, 1);
    RESET = 1'b1; force_busy = 1'b1;
    @(negedge CLK);
    check("t5_rst_read", MEM_READ, 0);
    check("t5_rst_write", MEM_WRITE, 0);
    check("t5_rst_d_rdata", D_READDATA, 0);
    check("t5_rst_d_bw", D_BUSYWAIT, 1);
    RESET = 1'b0;
    strobes = 0;
    repeat (5) begin
      @(negedge CLK);
      if (MEM_READ || MEM_WRITE) strobes++;
    end
    check("t5_no_grant_busy", strobes, 0);
    force_busy = 1'b0;
    @(negedge CLK);
    check("t5_grant_read", MEM_READ, 1);
    check("t5_grant_addr", MEM_ADDRESS, 6'h07);
    wait_done(1'b1, 20, n);
    D_READ = 1'b0;
    check("t5_done_cycles", n, 7);
    check("t5_d_rdata", D_READDATA, 32'hCAFEF00D);
    repeat (2) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
